// File: rtl/packet_transfer_scheduler_pkg.sv
// Shared types for the packet transfer scheduler: scheduler state encoding and slot index type.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package packet_transfer_scheduler_pkg;

   localparam int NUM_SLOTS_DEF      = 8;
   localparam int CPU_MAX_WAIT_DEF   = 4;
   localparam int TIMEOUT_CYCLES_DEF = 1024;
   localparam int SLOT_W_DEF         = $clog2(NUM_SLOTS_DEF);

   typedef logic [SLOT_W_DEF-1:0] slot_index_t;

   typedef enum logic [1:0] {
      ST_ARB        = 2'd0,
      ST_GRANT_SLOT = 2'd1,
      ST_GRANT_CPU  = 2'd2,
      ST_RELEASE    = 2'd3
   } sched_state_t;

endpackage

// File: rtl/packet_rr_arbiter.sv
// Round-robin pick among slot requests: first set bit strictly after ptr, wrapping (ptr itself last).
// Latency: combinational.
// Backpressure: none; caller decides when to consume the pick.
module packet_rr_arbiter
   import packet_transfer_scheduler_pkg::*;
#(
   parameter int NUM_SLOTS = 8,
   localparam int SLOT_W   = $clog2(NUM_SLOTS)
) (
   input  logic [NUM_SLOTS-1:0] req,
   input  logic [SLOT_W-1:0]    ptr,
   output logic                 grant_valid,
   output logic [SLOT_W-1:0]    grant_index
);

   // Scan from farthest to nearest so the nearest requester after ptr is the last (winning) assignment.
   always_comb begin
      logic [SLOT_W-1:0] idx;
      grant_valid = 1'b0;
      grant_index = '0;
      idx         = '0;
      for (int i = NUM_SLOTS; i >= 1; i--) begin
         idx = ptr + SLOT_W'(i);
         if (req[idx]) begin
            grant_valid = 1'b1;
            grant_index = idx;
         end
      end
   end

endmodule

// File: rtl/packet_transfer_scheduler.sv
// Shares one transfer buffer among completed-packet slots (round-robin) and the CPU (starvation-bounded).
// Latency: request seen in ARB -> valid next cycle; grant + 1 RELEASE cycle + 1 ARB cycle per packet.
// Backpressure: grant held until the buffer's completion pulse; watchdog flags but never aborts.
module packet_transfer_scheduler
   import packet_transfer_scheduler_pkg::*;
#(
   parameter int NUM_SLOTS      = NUM_SLOTS_DEF,
   parameter int CPU_MAX_WAIT   = CPU_MAX_WAIT_DEF,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
   localparam int SLOT_W        = $clog2(NUM_SLOTS)
) (
   input  logic                 nocclk,
   input  logic                 rst_n,
   input  logic [NUM_SLOTS-1:0] slot_ready,
   output logic [SLOT_W-1:0]    sel_slot,
   output logic                 transfered_packet_valid,
   input  logic                 transfered_packet_completed,
   input  logic                 cpu_packet_pending,
   output logic                 cpu_transfered_packet_valid,
   input  logic                 cpu_transfered_packet_completed,
   output logic                 slot_free_valid,
   output logic [SLOT_W-1:0]    slot_free_index,
   output logic                 cpu_done,
   output logic                 timeout_error,
   input  logic                 clear_error
);

   localparam int WAIT_W = $clog2(CPU_MAX_WAIT + 1);
   localparam int WD_W   = $clog2(TIMEOUT_CYCLES);
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(CPU_MAX_WAIT);
   localparam logic [WD_W-1:0]   WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
   localparam logic [WD_W-1:0]   WD_ARM   = WD_W'(TIMEOUT_CYCLES - 2);

   sched_state_t      state, state_nxt;
   logic [SLOT_W-1:0] rr_ptr, rr_ptr_nxt;
   logic [WAIT_W-1:0] cpu_wait_cnt, cpu_wait_cnt_nxt;
   logic [WD_W-1:0]   wd_cnt, wd_cnt_nxt;
   logic [SLOT_W-1:0] sel_slot_nxt, slot_free_index_nxt;
   logic              slot_valid_nxt, cpu_valid_nxt, slot_free_valid_nxt, cpu_done_nxt;
   logic              err_set;
   logic              arb_valid;
   logic [SLOT_W-1:0] arb_index;
   logic              force_cpu;

   packet_rr_arbiter #(.NUM_SLOTS(NUM_SLOTS)) u_arb (
      .req         (slot_ready),
      .ptr         (rr_ptr),
      .grant_valid (arb_valid),
      .grant_index (arb_index)
   );

   assign force_cpu = cpu_packet_pending && (cpu_wait_cnt == WAIT_MAX);

   // FSM state register; reset drops any open grant immediately.
   always_ff @(posedge nocclk or negedge rst_n) begin
      if (!rst_n) state <= ST_ARB;
      else        state <= state_nxt;
   end

   // Next state plus next values of every registered output and counter.
   always_comb begin
      state_nxt           = state;
      rr_ptr_nxt          = rr_ptr;
      cpu_wait_cnt_nxt    = cpu_wait_cnt;
      wd_cnt_nxt          = wd_cnt;
      sel_slot_nxt        = sel_slot;
      slot_free_index_nxt = slot_free_index;
      slot_valid_nxt      = 1'b0;
      cpu_valid_nxt       = 1'b0;
      slot_free_valid_nxt = 1'b0;
      cpu_done_nxt        = 1'b0;
      err_set             = 1'b0;
      case (state)
         ST_ARB: begin
            if (force_cpu || (!arb_valid && cpu_packet_pending)) begin
               state_nxt        = ST_GRANT_CPU;
               cpu_valid_nxt    = 1'b1;
               cpu_wait_cnt_nxt = '0;
               wd_cnt_nxt       = '0;
            end else if (arb_valid) begin
               state_nxt      = ST_GRANT_SLOT;
               slot_valid_nxt = 1'b1;
               sel_slot_nxt   = arb_index;
               rr_ptr_nxt     = arb_index;
               wd_cnt_nxt     = '0;
               if (cpu_packet_pending && cpu_wait_cnt != WAIT_MAX)
                  cpu_wait_cnt_nxt = cpu_wait_cnt + 1'b1;
            end
         end
         ST_GRANT_SLOT: begin
            if (transfered_packet_completed) begin
               state_nxt           = ST_RELEASE;
               slot_free_valid_nxt = 1'b1;
               slot_free_index_nxt = sel_slot;
            end else begin
               slot_valid_nxt = 1'b1;
               err_set        = (wd_cnt == WD_ARM);
               if (wd_cnt != WD_LAST) wd_cnt_nxt = wd_cnt + 1'b1;
            end
         end
         ST_GRANT_CPU: begin
            if (cpu_transfered_packet_completed) begin
               state_nxt    = ST_RELEASE;
               cpu_done_nxt = 1'b1;
            end else begin
               cpu_valid_nxt = 1'b1;
               err_set       = (wd_cnt == WD_ARM);
               if (wd_cnt != WD_LAST) wd_cnt_nxt = wd_cnt + 1'b1;
            end
         end
         default: state_nxt = ST_ARB;
      endcase
   end

   // Output registers and arbitration/watchdog bookkeeping; set beats clear on the error flag.
   always_ff @(posedge nocclk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr                      <= SLOT_W'(NUM_SLOTS - 1);
         cpu_wait_cnt                <= '0;
         wd_cnt                      <= '0;
         sel_slot                    <= '0;
         transfered_packet_valid     <= 1'b0;
         cpu_transfered_packet_valid <= 1'b0;
         slot_free_valid             <= 1'b0;
         slot_free_index             <= '0;
         cpu_done                    <= 1'b0;
         timeout_error               <= 1'b0;
      end else begin
         rr_ptr                      <= rr_ptr_nxt;
         cpu_wait_cnt                <= cpu_wait_cnt_nxt;
         wd_cnt                      <= wd_cnt_nxt;
         sel_slot                    <= sel_slot_nxt;
         transfered_packet_valid     <= slot_valid_nxt;
         cpu_transfered_packet_valid <= cpu_valid_nxt;
         slot_free_valid             <= slot_free_valid_nxt;
         slot_free_index             <= slot_free_index_nxt;
         cpu_done                    <= cpu_done_nxt;
         if (err_set)          timeout_error <= 1'b1;
         else if (clear_error) timeout_error <= 1'b0;
      end
   end

endmodule

// File: tb/tb_packet_transfer_scheduler.sv
// Directed bench for packet_transfer_scheduler: round-robin order, CPU starvation bound, stray completions,
// watchdog with set-beats-clear, and asynchronous reset mid-grant; invariants watched every cycle.
// Inputs change 1 time unit after the rising edge; outputs are sampled there or on the falling edge.
module tb_packet_transfer_scheduler;
   import packet_transfer_scheduler_pkg::*;

   logic        nocclk;
   logic        rst_n;
   logic [7:0]  slot_ready;
   logic [2:0]  sel_slot;
   logic        transfered_packet_valid;
   logic        transfered_packet_completed;
   logic        cpu_packet_pending;
   logic        cpu_transfered_packet_valid;
   logic        cpu_transfered_packet_completed;
   logic        slot_free_valid;
   logic [2:0]  slot_free_index;
   logic        cpu_done;
   logic        timeout_error;
   logic        clear_error;

   int n_cmp = 0;
   int n_err = 0;

   packet_transfer_scheduler #(
      .NUM_SLOTS(8), .CPU_MAX_WAIT(4), .TIMEOUT_CYCLES(16)
   ) dut (
      .nocclk                          (nocclk),
      .rst_n                           (rst_n),
      .slot_ready                      (slot_ready),
      .sel_slot                        (sel_slot),
      .transfered_packet_valid         (transfered_packet_valid),
      .transfered_packet_completed     (transfered_packet_completed),
      .cpu_packet_pending              (cpu_packet_pending),
      .cpu_transfered_packet_valid     (cpu_transfered_packet_valid),
      .cpu_transfered_packet_completed (cpu_transfered_packet_completed),
      .slot_free_valid                 (slot_free_valid),
      .slot_free_index                 (slot_free_index),
      .cpu_done                        (cpu_done),
      .timeout_error                   (timeout_error),
      .clear_error                     (clear_error)
   );

   initial begin
      nocclk = 1'b0;
      forever #5 nocclk = ~nocclk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge nocclk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   // One full grant from ARB: enter grant, complete at once, check RELEASE, apply source updates, back to ARB.
   task automatic do_grant(input string tag, input bit is_cpu, input logic [2:0] exp_sel,
                           input logic [7:0] nxt_ready, input logic nxt_pending);
      step();
      check({tag, ".slot_valid"}, 32'(transfered_packet_valid), 32'(!is_cpu));
      check({tag, ".cpu_valid"}, 32'(cpu_transfered_packet_valid), 32'(is_cpu));
      if (!is_cpu) check({tag, ".sel"}, 32'(sel_slot), 32'(exp_sel));
      if (is_cpu) cpu_transfered_packet_completed = 1'b1;
      else        transfered_packet_completed     = 1'b1;
      step();
      cpu_transfered_packet_completed = 1'b0;
      transfered_packet_completed     = 1'b0;
      check({tag, ".rel_valids"}, 32'({transfered_packet_valid, cpu_transfered_packet_valid}), 32'd0);
      check({tag, ".free_valid"}, 32'(slot_free_valid), 32'(!is_cpu));
      check({tag, ".cpu_done"}, 32'(cpu_done), 32'(is_cpu));
      if (!is_cpu) check({tag, ".free_index"}, 32'(slot_free_index), 32'(exp_sel));
      slot_ready         = nxt_ready;
      cpu_packet_pending = nxt_pending;
      step();
      check({tag, ".pulse_end"}, 32'({slot_free_valid, cpu_done}), 32'd0);
   endtask

   // Every cycle: never both valids, and the selected slot holds steady across a grant.
   slot_index_t prev_sel;
   logic        prev_valid = 1'b0;
   always @(negedge nocclk) begin
      n_cmp++;
      assert (!(transfered_packet_valid && cpu_transfered_packet_valid)) else begin
         n_err++;
         $error("FAIL inv_both_valid: observed=11 expected=not both");
      end
      if (prev_valid && transfered_packet_valid) begin
         n_cmp++;
         assert (sel_slot === prev_sel) else begin
            n_err++;
            $error("FAIL inv_sel_stable: observed=%0d expected=%0d", sel_slot, prev_sel);
         end
      end
      prev_valid = transfered_packet_valid;
      prev_sel   = sel_slot;
   end

   initial begin
      rst_n                           = 1'b0;
      slot_ready                      = 8'h00;
      transfered_packet_completed     = 1'b0;
      cpu_packet_pending              = 1'b0;
      cpu_transfered_packet_completed = 1'b0;
      clear_error                     = 1'b0;
      #3;
      check("reset.outputs", 32'({transfered_packet_valid, cpu_transfered_packet_valid, slot_free_valid,
                                  cpu_done, timeout_error}), 32'd0);
      check("reset.sel", 32'(sel_slot), 32'd0);
      check("reset.free_index", 32'(slot_free_index), 32'd0);
      step();
      step();
      rst_n = 1'b1;

      // Slots 0 and 2 ready, no CPU: 0, then 2, then idle, then 0 again once re-readied.
      slot_ready = 8'h05;
      do_grant("t1a", 1'b0, 3'd0, 8'h04, 1'b0);
      do_grant("t1b", 1'b0, 3'd2, 8'h00, 1'b0);
      step();
      check("t1.idle", 32'({transfered_packet_valid, cpu_transfered_packet_valid}), 32'd0);
      slot_ready = 8'h01;
      do_grant("t1c", 1'b0, 3'd0, 8'h00, 1'b0);

      // All slots ready with CPU pending: four slot grants, forced CPU, then slot 4.
      do_reset();
      slot_ready         = 8'hFF;
      cpu_packet_pending = 1'b1;
      do_grant("t2s0", 1'b0, 3'd0, 8'hFF, 1'b1);
      do_grant("t2s1", 1'b0, 3'd1, 8'hFF, 1'b1);
      do_grant("t2s2", 1'b0, 3'd2, 8'hFF, 1'b1);
      do_grant("t2s3", 1'b0, 3'd3, 8'hFF, 1'b1);
      do_grant("t2cpu", 1'b1, 3'd0, 8'hFF, 1'b0);
      do_grant("t2s4", 1'b0, 3'd4, 8'h00, 1'b0);

      // Completion during ARB is ignored; stray CPU completion during a slot grant is ignored.
      slot_ready                  = 8'h20;
      transfered_packet_completed = 1'b1;
      step();
      transfered_packet_completed = 1'b0;
      check("t3.grant_valid", 32'(transfered_packet_valid), 32'd1);
      check("t3.grant_sel", 32'(sel_slot), 32'd5);
      check("t3.no_free_at_start", 32'(slot_free_valid), 32'd0);
      cpu_transfered_packet_completed = 1'b1;
      step();
      cpu_transfered_packet_completed = 1'b0;
      check("t3.stray_valid", 32'(transfered_packet_valid), 32'd1);
      check("t3.stray_pulses", 32'({slot_free_valid, cpu_done}), 32'd0);
      step();
      check("t3.still_valid", 32'(transfered_packet_valid), 32'd1);
      transfered_packet_completed = 1'b1;
      step();
      transfered_packet_completed = 1'b0;
      check("t3.free_valid", 32'(slot_free_valid), 32'd1);
      check("t3.free_index", 32'(slot_free_index), 32'd5);
      slot_ready = 8'h00;
      step();

      // Watchdog: error visible on the 16th grant cycle, grant kept; set wins over clear, then clear works.
      slot_ready = 8'h40;
      step();
      check("t4.sel", 32'(sel_slot), 32'd6);
      check("t4.err_cycle1", 32'(timeout_error), 32'd0);
      for (int k = 2; k <= 15; k++) step();
      check("t4.err_cycle15", 32'(timeout_error), 32'd0);
      clear_error = 1'b1;
      step();
      check("t4.err_cycle16", 32'(timeout_error), 32'd1);
      check("t4.valid_cycle16", 32'(transfered_packet_valid), 32'd1);
      step();
      clear_error = 1'b0;
      check("t4.err_cleared", 32'(timeout_error), 32'd0);
      check("t4.valid_cycle17", 32'(transfered_packet_valid), 32'd1);
      step();
      check("t4.err_stays_clear", 32'(timeout_error), 32'd0);
      transfered_packet_completed = 1'b1;
      step();
      transfered_packet_completed = 1'b0;
      check("t4.free_index", 32'({slot_free_valid, slot_free_index}), 32'({1'b1, 3'd6}));
      slot_ready = 8'h00;
      step();

      // Reset mid-grant: valids drop without a clock, no free pulse, slot 0 wins first afterwards.
      slot_ready = 8'h80;
      step();
      check("t5.sel", 32'({transfered_packet_valid, sel_slot}), 32'({1'b1, 3'd7}));
      #1 rst_n = 1'b0;
      #1;
      check("t5.async_drop", 32'({transfered_packet_valid, cpu_transfered_packet_valid}), 32'd0);
      check("t5.no_free", 32'(slot_free_valid), 32'd0);
      slot_ready = 8'h81;
      step();
      check("t5.no_free_held", 32'(slot_free_valid), 32'd0);
      rst_n = 1'b1;
      do_grant("t5after", 1'b0, 3'd0, 8'h80, 1'b0);
      slot_ready = 8'h00;
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
